instr_stream_encoder: RTL and testbench

- Inverse of the control decoder: takes symbolic instruction requests (kind, ALU function, register fields, immediate/target) and packs them into 32-bit instruction words.
- Writes the packed words sequentially into instruction memory through a stallable write port.
- Used by the program loader and self-test sequencer to build programs for the superscalar core.
- One-deep output register with valid/ready flow control; a start/done state machine brackets each program.

---
 rtl/instr_stream_encoder_if.sv | 28 ++
 rtl/instr_stream_encoder.sv | 164 ++++++++++++++++
 tb/tb_instr_stream_encoder.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_stream_encoder_if.sv
// Request bus and instruction-memory write port of instr_stream_encoder.
interface instr_stream_encoder_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [2:0]        in_func;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ready;

  // master is the encoder; slave is the request source together with the memory
  modport master (
    input  in_valid, in_kind, in_func, in_rs, in_rt, in_rd, in_imm, in_target, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
  modport slave (
    output in_valid, in_kind, in_func, in_rs, in_rt, in_rd, in_imm, in_target, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_stream_encoder.sv
// Packs symbolic instruction requests into 32-bit words and streams them
// into instruction memory; a start/done FSM brackets each program.
module instr_stream_encoder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  instr_stream_encoder_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err_overflow,
  output logic                 err_illegal,
  output logic [ADDR_W:0]      count
);
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    issued_q, issued_d;
  logic [CNT_W-1:0]    count_d;
  logic                last_hlt_q, last_hlt_d;
  logic                busy_d, done_d, ovf_d, ill_d;
  logic                accept, wr_done, legal, is_hlt;

  function automatic logic [31:0] encode(
    input logic [2:0]  kind,
    input logic [2:0]  func,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [5:0] funct;
    if (func[2])
      funct = 6'b100001;
    else begin
      case (func[1:0])
        2'b00:   funct = 6'b100000;
        2'b01:   funct = 6'b100010;
        2'b10:   funct = 6'b100100;
        default: funct = 6'b100101;
      endcase
    end
    case (kind)
      3'd0:    encode = {6'b000000, rs, rt, rd, 5'b00000, funct};
      3'd1:    encode = {6'b100011, rs, rt, imm};
      3'd2:    encode = {6'b101011, rs, rt, imm};
      3'd3:    encode = {6'b000100, rs, rt, imm};
      3'd4:    encode = {6'b000010, target};
      default: encode = {6'b111111, 26'd0};
    endcase
  endfunction

  assign legal         = (bus.in_kind <= 3'd5);
  assign is_hlt        = (bus.in_kind == 3'd5);
  assign bus.in_ready  = (state == S_RUN) && (!we_q || bus.imem_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign wr_done       = we_q && bus.imem_ready;
  assign bus.imem_we   = we_q;
  assign bus.imem_addr = waddr_q;
  assign bus.imem_wdata = wdata_q;

  // Next-state and next-register values
  always_comb begin
    state_d    = state;
    we_d       = we_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    issued_d   = issued_q;
    count_d    = count + CNT_W'(wr_done);
    last_hlt_d = last_hlt_q;
    done_d     = done;
    ovf_d      = err_overflow;
    ill_d      = err_illegal;

    if (wr_done) we_d = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_RUN;
          addr_d   = base_addr;
          count_d  = '0;
          issued_d = '0;
          done_d   = 1'b0;
          ovf_d    = 1'b0;
          ill_d    = 1'b0;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (!legal) begin
            ill_d = 1'b1;
          end else begin
            we_d     = 1'b1;
            waddr_d  = addr_q;
            wdata_d  = encode(bus.in_kind, bus.in_func, bus.in_rs, bus.in_rt,
                              bus.in_rd, bus.in_imm, bus.in_target);
            addr_d   = addr_q + ADDR_W'(1);
            issued_d = issued_q + CNT_W'(1);
            if (is_hlt) begin
              state_d    = S_DRAIN;
              last_hlt_d = 1'b1;
            end else if (issued_q == CNT_W'(DEPTH - 1)) begin
              // Last slot taken by a non-HLT word: keep it, flag overflow
              state_d    = S_DRAIN;
              last_hlt_d = 1'b0;
              ovf_d      = 1'b1;
            end
          end
        end
      end
      S_DRAIN: begin
        if (wr_done) begin
          state_d = S_DONE;
          done_d  = last_hlt_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      addr_q       <= '0;
      issued_q     <= '0;
      count        <= '0;
      last_hlt_q   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_overflow <= 1'b0;
      err_illegal  <= 1'b0;
    end else begin
      state        <= state_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      addr_q       <= addr_d;
      issued_q     <= issued_d;
      count        <= count_d;
      last_hlt_q   <= last_hlt_d;
      busy         <= busy_d;
      done         <= done_d;
      err_overflow <= ovf_d;
      err_illegal  <= ill_d;
    end
  end
endmodule

// File: tb/tb_instr_stream_encoder.sv
// Directed bench for instr_stream_encoder with a scoreboard of expected memory writes.
module tb_instr_stream_encoder;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              busy, done, err_overflow, err_illegal;
  logic [ADDR_W:0]   count;

  instr_stream_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_stream_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .bus          (bus.master),
    .busy         (busy),
    .done         (done),
    .err_overflow (err_overflow),
    .err_illegal  (err_illegal),
    .count        (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] word;
    int          acc_cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [7:0]  model_addr = 8'd0;
  int          exp_count  = 0;
  bit          model_run  = 1'b0;
  bit          head_seen  = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_addr  = 8'd0;
  logic [31:0] prev_data  = 32'd0;
  int          w;

  int unsigned opc_tab   [6] = '{0, 35, 43, 4, 2, 63};
  int unsigned funct_tab [4] = '{32, 34, 36, 37};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word value from the instruction-format rules, using plain arithmetic
  function automatic logic [31:0] model_word(input int unsigned kind, input int unsigned func,
                                             input int unsigned rs, input int unsigned rt,
                                             input int unsigned rd, input int unsigned imm,
                                             input int unsigned tgt);
    int unsigned v;
    v = opc_tab[kind] * 32'h0400_0000;
    if (kind == 0)
      v = v + rs * 32'h20_0000 + rt * 32'h1_0000 + rd * 32'h800 +
          ((func >= 4) ? 33 : funct_tab[func]);
    else if (kind <= 3)
      v = v + rs * 32'h20_0000 + rt * 32'h1_0000 + imm;
    else if (kind == 4)
      v = v + tgt;
    return 32'(v);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle checker: count, output hold, write latency, address and data order
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_count  = 0;
      head_seen  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("count", 32'(count), 32'(exp_count));
      if (prev_stall) begin
        chk("hold_we", 32'(bus.imem_we), 32'd1);
        chk("hold_addr", 32'(bus.imem_addr), 32'(prev_addr));
        chk("hold_data", bus.imem_wdata, prev_data);
      end
      if (bus.imem_we) begin
        if (sb.size() == 0) begin
          chk("spurious_we", 32'(bus.imem_we), 32'd0);
        end else begin
          if (!head_seen) begin
            chk("latency", 32'(cyc), 32'(sb[0].acc_cyc + 1));
            head_seen = 1'b1;
          end
          if (bus.imem_ready) begin
            chk("waddr", 32'(bus.imem_addr), 32'(sb[0].addr));
            chk("wdata", bus.imem_wdata, sb[0].word);
            void'(sb.pop_front());
            head_seen = 1'b0;
            exp_count++;
          end
        end
      end
      prev_stall = bus.imem_we && !bus.imem_ready;
      prev_addr  = bus.imem_addr;
      prev_data  = bus.imem_wdata;
      if (start && !model_run) exp_count = 0;
    end
  end

  // Called and returns at posedge+1; optional literal check of the word that appears
  task automatic send(input logic [2:0] k, input logic [2:0] f, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                      input logic [25:0] tgt, input bit do_lit, input logic [31:0] lit_word,
                      input logic [7:0] lit_addr, output int waits);
    bit acc;
    acc   = 1'b0;
    waits = 0;
    bus.in_valid  = 1'b1;
    bus.in_kind   = k;
    bus.in_func   = f;
    bus.in_rs     = rs;
    bus.in_rt     = rt;
    bus.in_rd     = rd;
    bus.in_imm    = imm;
    bus.in_target = tgt;
    while (!acc && waits < 40) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1'b1;
        if (k <= 3'd5) begin
          sb.push_back('{addr: model_addr,
                         word: model_word(int'(k), int'(f), int'(rs), int'(rt), int'(rd),
                                          int'(imm), int'(tgt)),
                         acc_cyc: cyc});
          model_addr = model_addr + 8'd1;
        end
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("accepted", 32'(acc), 32'd1);
    if (do_lit) begin
      chk("lit_we", 32'(bus.imem_we), 32'd1);
      chk("lit_addr", 32'(bus.imem_addr), 32'(lit_addr));
      chk("lit_word", bus.imem_wdata, lit_word);
    end
  endtask

  task automatic do_start(input logic [7:0] b);
    start      = 1'b1;
    base_addr  = b;
    model_addr = b;
    @(posedge clk);
    #1;
    start     = 1'b0;
    model_run = 1'b1;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_count", 32'(count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0;
    bus.in_valid = 1'b0; bus.in_kind = '0; bus.in_func = '0; bus.in_rs = '0;
    bus.in_rt = '0; bus.in_rd = '0; bus.in_imm = '0; bus.in_target = '0;
    bus.imem_ready = 1'b1;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_we", 32'(bus.imem_we), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_wdata", bus.imem_wdata, 32'd0);
    chk("rst_status", 32'({busy, done, err_overflow, err_illegal}), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Program 1: back-to-back words, HLT landing in the last slot
    do_start(8'h10);
    send(3'd0, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h0022_1820, 8'h10, w);
    send(3'd1, 3'd0, 5'd4, 5'd5, 5'd0, 16'h0008, 26'h0, 1'b1, 32'h8C85_0008, 8'h11, w);
    chk("lw_b2b_waits", 32'(w), 32'd0);
    send(3'd2, 3'd0, 5'd4, 5'd5, 5'd0, 16'hFFFC, 26'h0, 1'b1, 32'hAC85_FFFC, 8'h12, w);
    chk("sw_b2b_waits", 32'(w), 32'd0);
    send(3'd5, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1, 32'hFC00_0000, 8'h13, w);
    chk("hlt_done_early", 32'(done), 32'd0);
    chk("hlt_busy_drain", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("p1_done", 32'(done), 32'd1);
    chk("p1_busy", 32'(busy), 32'd0);
    chk("p1_count", 32'(count), 32'd4);
    chk("p1_ovf", 32'(err_overflow), 32'd0);
    bus.in_valid = 1'b1;
    #1;
    chk("p1_ready_after_done", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    model_run = 1'b0;
    @(posedge clk); #1;

    // Program 2: stalled JMP, illegal kind, ignored start, address wrap
    do_start(8'hFE);
    chk("p2_done_cleared", 32'(done), 32'd0);
    bus.imem_ready = 1'b0;
    send(3'd4, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40, 1'b1, 32'h0800_0040, 8'hFE, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_we", 32'(bus.imem_we), 32'd1);
      chk("stall_addr", 32'(bus.imem_addr), 32'h0000_00FE);
      chk("stall_wdata", bus.imem_wdata, 32'h0800_0040);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.imem_ready = 1'b1;
    @(posedge clk); #1;
    chk("jmp_we_drop", 32'(bus.imem_we), 32'd0);
    chk("jmp_count", 32'(count), 32'd1);
    send(3'd6, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0, 32'h0, 8'h0, w);
    chk("ill_flag", 32'(err_illegal), 32'd1);
    chk("ill_no_we", 32'(bus.imem_we), 32'd0);
    chk("ill_count", 32'(count), 32'd1);
    start = 1'b1; base_addr = 8'h80;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_start_busy", 32'(busy), 32'd1);
    send(3'd0, 3'd1, 5'd31, 5'd0, 5'd31, 16'h0, 26'h0, 1'b1, 32'h03E0_F822, 8'hFF, w);
    send(3'd5, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1, 32'hFC00_0000, 8'h00, w);
    @(posedge clk); #1;
    chk("p2_done", 32'(done), 32'd1);
    chk("p2_ill_sticky", 32'(err_illegal), 32'd1);
    chk("p2_count", 32'(count), 32'd3);
    model_run = 1'b0;

    // Program 3: four non-HLT words into a four-word program overflow
    do_start(8'h20);
    chk("p3_ill_cleared", 32'(err_illegal), 32'd0);
    chk("p3_done_cleared", 32'(done), 32'd0);
    send(3'd0, 3'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h0022_1824, 8'h20, w);
    send(3'd0, 3'd3, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h0022_1825, 8'h21, w);
    send(3'd0, 3'd6, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h0022_1821, 8'h22, w);
    chk("p3_no_ovf_yet", 32'(err_overflow), 32'd0);
    send(3'd0, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h0022_1820, 8'h23, w);
    chk("p3_ovf", 32'(err_overflow), 32'd1);
    chk("p3_drain_busy", 32'(busy), 32'd1);
    chk("p3_drain_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("p3_done", 32'(done), 32'd0);
    chk("p3_busy", 32'(busy), 32'd0);
    chk("p3_count", 32'(count), 32'd4);
    chk("p3_we", 32'(bus.imem_we), 32'd0);
    model_run = 1'b0;

    // Program 4: asynchronous reset while a write is stalled
    do_start(8'h30);
    bus.imem_ready = 1'b0;
    send(3'd0, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h0022_1820, 8'h30, w);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_we", 32'(bus.imem_we), 32'd0);
    chk("arst_addr", 32'(bus.imem_addr), 32'd0);
    chk("arst_wdata", bus.imem_wdata, 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("arst_status", 32'({busy, done, err_overflow, err_illegal}), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_run = 1'b0;
    bus.imem_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_we", 32'(bus.imem_we), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
